led_pattern_ctrl: RTL and testbench

Button-driven LED pattern controller for the 4-LED board I/O. It synchronises and debounces a raw pushbutton, steps a 4-state mode machine on each debounced press, and drives `led[3:0]` with a timed pattern for the active mode. It runs from the 1 MHz system clock and replaces the direct `en`-to-LED toggling used by the simpler board demos.

---
 rtl/led_pattern_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// led_pattern_ctrl
//
// Button-driven LED pattern controller for the 4-LED board I/O.
// A raw active-low pushbutton is synchronised and debounced. Each accepted
// press produces a one-cycle pulse that steps a four-mode machine:
// TOGGLE -> CHASE -> BOUNCE -> HOLD -> TOGGLE. The active mode drives led[3:0]
// with a pattern that advances once per prescaler tick while run_en is high.
//
// Parameters
//   DEBOUNCE_CYC : stable cycles needed before a new button level is accepted
//                  (>= 2)
//   TICK_CYC     : clock cycles per pattern step (>= 2)
//
// Ports
//   clk       in   system clock (1 MHz nominal)
//   n_reset   in   asynchronous active-low reset
//   btn_n     in   raw pushbutton, active-low, asynchronous, may bounce
//   run_en    in   pattern advance enable (synchronous)
//   led       out  [3:0] LED drive, registered
//   mode      out  [1:0] current mode, registered
//   btn_pulse out  one-cycle pulse per accepted press, registered
// -----------------------------------------------------------------------------
module led_pattern_ctrl #(
    parameter int DEBOUNCE_CYC = 20000,
    parameter int TICK_CYC     = 250000
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       btn_n,
    input  logic       run_en,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic       btn_pulse
);

    // -------------------------------------------------------------------------
    // Local parameters and types
    // -------------------------------------------------------------------------
    localparam int DB_W = $clog2(DEBOUNCE_CYC);
    localparam int TK_W = $clog2(TICK_CYC);

    // Terminal counts, sized to their counters.
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TK_W-1:0] TK_MAX = TK_W'(TICK_CYC - 1);

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    typedef enum logic [1:0] {
        ST_TOGGLE = 2'd0,
        ST_CHASE  = 2'd1,
        ST_BOUNCE = 2'd2,
        ST_HOLD   = 2'd3
    } mode_t;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Mode sequence followed on each accepted press.
    function automatic mode_t next_mode(input mode_t cur);
        mode_t nxt;
        case (cur)
            ST_TOGGLE: nxt = ST_CHASE;
            ST_CHASE:  nxt = ST_BOUNCE;
            ST_BOUNCE: nxt = ST_HOLD;
            ST_HOLD:   nxt = ST_TOGGLE;
            default:   nxt = ST_TOGGLE;
        endcase
        return nxt;
    endfunction

    // Pattern loaded on entry to a mode.
    function automatic logic [3:0] init_pattern(input mode_t m);
        logic [3:0] pat;
        case (m)
            ST_TOGGLE: pat = 4'b1111;
            ST_CHASE:  pat = 4'b0001;
            ST_BOUNCE: pat = 4'b0001;
            ST_HOLD:   pat = 4'b1010;
            default:   pat = 4'b1111;
        endcase
        return pat;
    endfunction

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    logic [1:0]      r_sync;
    logic            w_btn_s;

    logic            r_btn_db;
    logic [DB_W-1:0] r_db_cnt;
    logic            w_db_differ;
    logic            w_db_accept;

    logic            r_btn_pulse;

    mode_t           r_state;
    mode_t           w_state_nxt;
    logic [3:0]      r_led;
    logic [3:0]      w_led_nxt;
    logic            r_dir;
    logic            w_dir_nxt;
    logic [TK_W-1:0] r_tk_cnt;
    logic [TK_W-1:0] w_tk_cnt_nxt;
    logic            w_tick;

    // -------------------------------------------------------------------------
    // Synchroniser
    // -------------------------------------------------------------------------

    // Two-flop synchroniser; idles high so reset looks like a released button.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], btn_n};
        end
    end

    assign w_btn_s = r_sync[1];

    // -------------------------------------------------------------------------
    // Debouncer
    // -------------------------------------------------------------------------
    // The counter measures how long the synchronised level has disagreed with
    // the accepted level. Any return to the accepted level restarts the
    // window, so only a level held for DEBOUNCE_CYC consecutive cycles wins.
    assign w_db_differ = w_btn_s ^ r_btn_db;
    assign w_db_accept = w_db_differ && (r_db_cnt == DB_MAX);

    // Debounce counter and accepted button level.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_btn_db <= 1'b1;
            r_db_cnt <= '0;
        end else if (!w_db_differ) begin
            r_btn_db <= r_btn_db;
            r_db_cnt <= '0;
        end else if (w_db_accept) begin
            r_btn_db <= w_btn_s;
            r_db_cnt <= '0;
        end else begin
            r_btn_db <= r_btn_db;
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Press detect
    // -------------------------------------------------------------------------
    // The pulse is registered on the same edge that the accepted level falls,
    // so it is high exactly in the first cycle of the pressed state. Releases
    // (accepting a 1) never pulse.

    // One-cycle press pulse.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_btn_pulse <= 1'b0;
        end else begin
            r_btn_pulse <= w_db_accept & ~w_btn_s;
        end
    end

    // -------------------------------------------------------------------------
    // Mode FSM, prescaler and pattern generator
    // -------------------------------------------------------------------------
    assign w_tick = run_en && (r_tk_cnt == TK_MAX);

    // State, pattern, bounce direction and prescaler registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state  <= ST_TOGGLE;
            r_led    <= 4'b1111;
            r_dir    <= DIR_L;
            r_tk_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_led    <= w_led_nxt;
            r_dir    <= w_dir_nxt;
            r_tk_cnt <= w_tk_cnt_nxt;
        end
    end

    // Next-state and pattern logic. A press has priority over a tick in the
    // same cycle: the tick is dropped and the new mode starts fresh.
    always_comb begin
        w_state_nxt  = r_state;
        w_led_nxt    = r_led;
        w_dir_nxt    = r_dir;
        w_tk_cnt_nxt = r_tk_cnt;

        if (r_btn_pulse) begin
            w_state_nxt  = next_mode(r_state);
            w_led_nxt    = init_pattern(next_mode(r_state));
            w_dir_nxt    = DIR_L;
            w_tk_cnt_nxt = '0;
        end else if (run_en) begin
            if (w_tick) begin
                w_tk_cnt_nxt = '0;
                case (r_state)
                    ST_TOGGLE: begin
                        w_led_nxt = ~r_led;
                    end
                    ST_CHASE: begin
                        w_led_nxt = {r_led[2:0], r_led[3]};
                    end
                    ST_BOUNCE: begin
                        // Turn around at either end; otherwise keep moving.
                        if (r_led == 4'b1000) begin
                            w_led_nxt = 4'b0100;
                            w_dir_nxt = DIR_R;
                        end else if (r_led == 4'b0001) begin
                            w_led_nxt = 4'b0010;
                            w_dir_nxt = DIR_L;
                        end else if (r_dir == DIR_L) begin
                            w_led_nxt = {r_led[2:0], 1'b0};
                        end else begin
                            w_led_nxt = {1'b0, r_led[3:1]};
                        end
                    end
                    ST_HOLD: begin
                        w_led_nxt = r_led;
                    end
                    default: begin
                        w_led_nxt = r_led;
                    end
                endcase
            end else begin
                w_tk_cnt_nxt = r_tk_cnt + TK_W'(1);
            end
        end else begin
            // run_en low: prescaler and pattern hold their values.
            w_tk_cnt_nxt = r_tk_cnt;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign led       = r_led;
    assign mode      = r_state;
    assign btn_pulse = r_btn_pulse;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_ctrl
//
// Self-checking bench for led_pattern_ctrl with DEBOUNCE_CYC=4, TICK_CYC=5.
// A behavioural model tracks button history, the accepted level, the mode and
// the number of pattern steps since the mode was entered; the expected LED
// value is derived from (mode, steps) rather than from a shifted register.
// -----------------------------------------------------------------------------
module tb_led_pattern_ctrl;

    localparam int D = 4;
    localparam int T = 5;

    logic       clk     = 1'b0;
    logic       n_reset = 1'b1;
    logic       btn_n   = 1'b1;
    logic       run_en  = 1'b0;
    logic [3:0] led;
    logic [1:0] mode;
    logic       btn_pulse;

    int total = 0;
    int bad   = 0;

    // Model state
    bit m_s0, m_s1;     // button delayed by one and two edges
    bit m_db;           // accepted button level
    bit m_pulse;        // press pulse currently visible
    int m_run;          // consecutive edges the delayed button disagreed
    int m_mode;         // 0..3
    int m_phase;        // pattern steps since mode entry, modulo 12
    int m_tk;           // cycles into the current step period
    int m_cyc = 0;      // edge counter
    int m_entry = 0;    // edge at which the current mode was entered

    led_pattern_ctrl #(
        .DEBOUNCE_CYC(D),
        .TICK_CYC    (T)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .btn_n    (btn_n),
        .run_en   (run_en),
        .led      (led),
        .mode     (mode),
        .btn_pulse(btn_pulse)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    function automatic logic [3:0] model_led();
        logic [3:0] v;
        case (m_mode)
            0: v = (m_phase % 2 == 0) ? 4'b1111 : 4'b0000;
            1: v = 4'(1 << (m_phase % 4));
            2: begin
                case (m_phase % 6)
                    0: v = 4'b0001;
                    1: v = 4'b0010;
                    2: v = 4'b0100;
                    3: v = 4'b1000;
                    4: v = 4'b0100;
                    default: v = 4'b0010;
                endcase
            end
            default: v = 4'b1010;
        endcase
        return v;
    endfunction

    function automatic logic [6:0] m_out();
        logic [1:0] mm;
        mm = m_mode[1:0];
        return {model_led(), mm, m_pulse};
    endfunction

    task automatic model_reset();
        m_s0 = 1'b1; m_s1 = 1'b1; m_db = 1'b1; m_pulse = 1'b0;
        m_run = 0; m_mode = 0; m_phase = 0; m_tk = 0; m_entry = m_cyc;
    endtask

    task automatic model_edge();
        bit n_pulse;
        // mode / pattern, driven by the pulse visible before this edge
        if (m_pulse) begin
            m_mode  = (m_mode + 1) % 4;
            m_phase = 0;
            m_tk    = 0;
            m_entry = m_cyc;
        end else if (run_en) begin
            if (m_tk == T - 1) begin
                m_tk    = 0;
                m_phase = (m_phase + 1) % 12;
            end else begin
                m_tk = m_tk + 1;
            end
        end
        // accept a level only after D consecutive disagreeing samples
        n_pulse = 1'b0;
        if (m_s1 != m_db) begin
            m_run = m_run + 1;
            if (m_run == D) begin
                m_db    = m_s1;
                m_run   = 0;
                n_pulse = (m_s1 == 1'b0);
            end
        end else begin
            m_run = 0;
        end
        m_pulse = n_pulse;
        m_s1 = m_s0;
        m_s0 = btn_n;
    endtask

    task automatic cyc();
        @(posedge clk);
        m_cyc = m_cyc + 1;
        if (!n_reset) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic do_reset();
        btn_n = 1'b1;
        run_en = 1'b0;
        n_reset = 1'b0;
        model_reset();
        repeat (3) cyc();
        n_reset = 1'b1;
    endtask

    task automatic press();
        btn_n = 1'b0;
        repeat (12) cyc();
        btn_n = 1'b1;
        repeat (12) cyc();
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        btn_n = 1'b1;
        run_en = 1'b0;
        #1 n_reset = 1'b0;
        model_reset();
        #2;
        if ({led, mode, btn_pulse} !== 7'b1111_00_0) begin
            bad++;
            $display("FAIL reset_async got=%b want=%b", {led, mode, btn_pulse}, 7'b1111_00_0);
        end
        total++;
        repeat (3) cyc();
        n_reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if ({led, mode, btn_pulse} !== 7'b1111_00_0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, {led, mode, btn_pulse}, 7'b1111_00_0);
            end
            total++;
        end
    endtask

    task automatic test_bounce_reject();
        int pulses;
        pulses = 0;
        btn_n = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) btn_n = 1'b1;
            cyc();
            if (btn_pulse) pulses++;
            if ({led, mode, btn_pulse} !== m_out()) begin
                bad++;
                $display("FAIL glitch_track cyc=%0d got=%b want=%b", i, {led, mode, btn_pulse}, m_out());
            end
            total++;
        end
        if (pulses !== 0 || mode !== 2'd0) begin
            bad++;
            $display("FAIL glitch_reject pulses=%0d mode=%0d want pulses=0 mode=0", pulses, mode);
        end
        total++;
        btn_n = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 12) btn_n = 1'b1;
            cyc();
            if (btn_pulse) pulses++;
            if ({led, mode, btn_pulse} !== m_out()) begin
                bad++;
                $display("FAIL press_track cyc=%0d got=%b want=%b", i, {led, mode, btn_pulse}, m_out());
            end
            total++;
        end
        if (pulses !== 1 || mode !== 2'd1 || led !== 4'b0001) begin
            bad++;
            $display("FAIL press_once pulses=%0d mode=%0d led=%b want pulses=1 mode=1 led=0001", pulses, mode, led);
        end
        total++;
    endtask

    task automatic test_chase();
        logic [3:0] exp_seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        run_en = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            cyc();
            if ({led, mode, btn_pulse} !== m_out()) begin
                bad++;
                $display("FAIL chase_track cyc=%0d got=%b want=%b", i, {led, mode, btn_pulse}, m_out());
            end
            total++;
            if (i % 5 == 0 && i <= 20) begin
                if (led !== exp_seq[i / 5 - 1]) begin
                    bad++;
                    $display("FAIL chase_step at=+%0d got=%b want=%b", i, led, exp_seq[i / 5 - 1]);
                end
                total++;
            end
        end
        // prescaler is two cycles into its period; freeze it there
        run_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            if (led !== 4'b0001) begin
                bad++;
                $display("FAIL chase_freeze cyc=%0d got=%b want=0001", i, led);
            end
            total++;
        end
        run_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            if ({led, mode, btn_pulse} !== m_out()) begin
                bad++;
                $display("FAIL chase_resume_track cyc=%0d got=%b want=%b", i, {led, mode, btn_pulse}, m_out());
            end
            total++;
            if (led !== ((i < 3) ? 4'b0001 : 4'b0010)) begin
                bad++;
                $display("FAIL chase_resume cyc=%0d got=%b want=%b", i, led, (i < 3) ? 4'b0001 : 4'b0010);
            end
            total++;
        end
    endtask

    task automatic test_bounce_hold();
        logic [3:0] exp_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        logic [3:0] seen [$];
        logic [3:0] prev;
        do_reset();
        press();
        press();
        run_en = 1'b1;
        prev = led;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if ({led, mode, btn_pulse} !== m_out()) begin
                bad++;
                $display("FAIL bounce_track cyc=%0d got=%b want=%b", i, {led, mode, btn_pulse}, m_out());
            end
            total++;
            if (led !== prev) seen.push_back(led);
            prev = led;
        end
        for (int k = 0; k < 7; k++) begin
            if (k >= seen.size()) begin
                bad++;
                $display("FAIL bounce_seq step=%0d got=none want=%b", k, exp_seq[k]);
            end else if (seen[k] !== exp_seq[k]) begin
                bad++;
                $display("FAIL bounce_seq step=%0d got=%b want=%b", k, seen[k], exp_seq[k]);
            end
            total++;
        end
        press();
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (led !== 4'b1010 || mode !== 2'd3) begin
                bad++;
                $display("FAIL hold_static cyc=%0d led=%b mode=%0d want led=1010 mode=3", i, led, mode);
            end
            total++;
        end
    endtask

    task automatic test_toggle_coincide();
        int hits;
        bit found;
        int d;
        hits = 0;
        run_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            btn_n = (i < 12) ? 1'b0 : 1'b1;
            cyc();
            if ({led, mode, btn_pulse} !== m_out()) begin
                bad++;
                $display("FAIL toggle_track cyc=%0d got=%b want=%b", i, {led, mode, btn_pulse}, m_out());
            end
            total++;
            d = m_cyc - m_entry;
            if (m_mode == 0 && (d == 0 || d == 5 || d == 10)) begin
                hits++;
                if (led !== ((d == 5) ? 4'b0000 : 4'b1111)) begin
                    bad++;
                    $display("FAIL toggle_step at=+%0d got=%b want=%b", d, led, (d == 5) ? 4'b0000 : 4'b1111);
                end
                total++;
            end
        end
        if (hits !== 3) begin
            bad++;
            $display("FAIL toggle_entry hits=%0d want=3", hits);
        end
        total++;
        // time the press so the pulse lands on the last prescaler count
        found = 1'b0;
        for (int k = 0; k < 2 * T; k++) begin
            if ((m_tk + D + 2) % T == T - 1) begin
                found = 1'b1;
                break;
            end
            cyc();
        end
        if (!found) begin
            bad++;
            $display("FAIL coincide_align got=none want=aligned");
        end
        total++;
        btn_n = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i == 12) btn_n = 1'b1;
            cyc();
            if ({led, mode, btn_pulse} !== m_out()) begin
                bad++;
                $display("FAIL coincide_track cyc=%0d got=%b want=%b", i, {led, mode, btn_pulse}, m_out());
            end
            total++;
            d = m_cyc - m_entry;
            if (m_mode == 1 && (d == 0 || d == 4 || d == 5)) begin
                if (led !== ((d == 5) ? 4'b0010 : 4'b0001) || mode !== 2'd1) begin
                    bad++;
                    $display("FAIL coincide_load at=+%0d led=%b mode=%0d want led=%b mode=1", d, led, mode, (d == 5) ? 4'b0010 : 4'b0001);
                end
                total++;
            end
        end
    endtask

    task automatic test_async_reset();
        bit found;
        do_reset();
        press();
        run_en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if ({led, mode, btn_pulse} !== m_out()) begin
                bad++;
                $display("FAIL areset_track cyc=%0d got=%b want=%b", i, {led, mode, btn_pulse}, m_out());
            end
            total++;
            if (led === 4'b0100) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            bad++;
            $display("FAIL areset_wait got=timeout want=led 0100");
        end
        total++;
        #3 n_reset = 1'b0;
        model_reset();
        #1;
        if ({led, mode, btn_pulse} !== 7'b1111_00_0) begin
            bad++;
            $display("FAIL areset_now got=%b want=%b", {led, mode, btn_pulse}, 7'b1111_00_0);
        end
        total++;
        repeat (2) cyc();
        n_reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if ({led, mode, btn_pulse} !== m_out()) begin
                bad++;
                $display("FAIL areset_after cyc=%0d got=%b want=%b", i, {led, mode, btn_pulse}, m_out());
            end
            total++;
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                btn_n = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) hold = $urandom_range(8, 20);
                else hold = $urandom_range(1, 6);
            end
            hold = hold - 1;
            if ($urandom_range(0, 15) == 0) run_en = ~run_en;
            cyc();
            if ({led, mode, btn_pulse} !== m_out()) begin
                bad++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, {led, mode, btn_pulse}, m_out());
            end
            total++;
        end
    endtask

    initial begin
        test_reset();
        test_bounce_reject();
        test_chase();
        test_bounce_hold();
        test_toggle_coincide();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
